fpu_align_stage: RTL

- Pipelined significand-alignment stage of the FP adder, directly downstream of the operand-swap block.
- Takes the big/small exponent and significand pair and right-shifts the small significand by the exponent difference.
- Extends both significands with guard/round/sticky (GRS) bits and forwards the result to the add/subtract stage.
- Two register stages with valid/ready backpressure; full throughput of one operation per cycle.

---
 rtl/fpu_align_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/fpu_align_stage.sv
// fpu_align_stage: two-stage significand alignment with GRS bits; optional FPU_ALIGN_STATS_EN adds sat_count
module fpu_align_stage #(
  parameter int SIG_W = 24,
  parameter int EXP_W = 8
`ifdef FPU_ALIGN_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   in_exp_big,
  input  logic [EXP_W-1:0]   in_exp_small,
  input  logic [SIG_W-1:0]   in_sig_big,
  input  logic [SIG_W-1:0]   in_sig_small,
  input  logic               in_sign_big,
  input  logic               in_eff_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   out_exp,
  output logic [SIG_W+2:0]   out_sig_big,
  output logic [SIG_W+2:0]   out_sig_small,
  output logic               out_sign,
  output logic               out_eff_sub,
  output logic               out_shift_sat
`ifdef FPU_ALIGN_STATS_EN
  , output logic [STAT_W-1:0] sat_count
`endif
);
  localparam int EXT_W = SIG_W + 3;
  logic             r_s1_valid, r_s1_sign, r_s1_eff_sub;
  logic [EXP_W-1:0] r_s1_diff, r_s1_exp;
  logic [EXT_W-1:0] r_s1_ext;
  logic [SIG_W-1:0] r_s1_sig_big;
  logic             r_s2_valid, r_s2_sign, r_s2_eff_sub, r_s2_sat;
  logic [EXP_W-1:0] r_s2_exp;
  logic [EXT_W-1:0] r_s2_sig_big, r_s2_sig_small;
  logic             w_s2_adv, w_s1_adv, w_accept, w_sat;
  logic [EXT_W-1:0] w_shifted, w_mask, w_sig_small;
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !rst;
  assign w_accept = in_valid && in_ready;
  // Right-shift the extended small significand, folding every discarded bit into the sticky LSB
  always_comb begin
    w_sat = 32'(r_s1_diff) >= EXT_W;
    w_mask = ~({EXT_W{1'b1}} << r_s1_diff);
    w_shifted = r_s1_ext >> r_s1_diff;
    w_sig_small = w_sat ? {{(EXT_W-1){1'b0}}, |r_s1_ext}
                        : {w_shifted[EXT_W-1:1], w_shifted[0] | (|(r_s1_ext & w_mask))};
  end
  // S1: capture operands and exponent difference on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_diff <= '0;
      r_s1_exp <= '0;
      r_s1_ext <= '0;
      r_s1_sig_big <= '0;
      r_s1_sign <= 1'b0;
      r_s1_eff_sub <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_diff <= in_exp_big - in_exp_small;
        r_s1_exp <= in_exp_big;
        r_s1_ext <= {in_sig_small, 3'b000};
        r_s1_sig_big <= in_sig_big;
        r_s1_sign <= in_sign_big;
        r_s1_eff_sub <= in_eff_sub;
      end
    end
  end
  // S2: register the aligned result; holds while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_exp <= '0;
      r_s2_sig_big <= '0;
      r_s2_sig_small <= '0;
      r_s2_sign <= 1'b0;
      r_s2_eff_sub <= 1'b0;
      r_s2_sat <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_exp <= r_s1_exp;
        r_s2_sig_big <= {r_s1_sig_big, 3'b000};
        r_s2_sig_small <= w_sig_small;
        r_s2_sign <= r_s1_sign;
        r_s2_eff_sub <= r_s1_eff_sub;
        r_s2_sat <= w_sat;
      end
    end
  end
  assign out_valid = r_s2_valid;
  assign out_exp = r_s2_exp;
  assign out_sig_big = r_s2_sig_big;
  assign out_sig_small = r_s2_sig_small;
  assign out_sign = r_s2_sign;
  assign out_eff_sub = r_s2_eff_sub;
  assign out_shift_sat = r_s2_sat;
`ifdef FPU_ALIGN_STATS_EN
  logic [STAT_W-1:0] r_sat_count;
  // Count delivered saturating results, sticking at all-ones
  always_ff @(posedge clk) begin
    if (rst) r_sat_count <= '0;
    else if (r_s2_valid && out_ready && r_s2_sat && !(&r_sat_count)) r_sat_count <= r_sat_count + 1'b1;
  end
  assign sat_count = r_sat_count;
`endif
endmodule
